// File: rtl/fifo_rr_mux.sv
// rtl/fifo_rr_mux.sv - per-channel FWFT FIFOs merged onto one stream by a locking round-robin arbiter
//
// Purpose: N_CH independent first-word-fall-through FIFOs, one per producer,
// drained through a single valid/ready output. The arbiter grants the first
// non-empty channel after the last popped one. Once a grant is presented and
// stalled, it is locked until popped or flushed.
//
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   s_valid/s_ready   per-channel write handshake (N_CH bits each)
//   s_data            packed write data, channel i at [i*WIDTH +: WIDTH]
//   flush             per-channel synchronous clear
//   m_valid/m_ready   output handshake
//   m_data, m_ch      head entry and index of the granted channel
//   occupancy         packed per-channel entry count (LOG_DEPTH+1 bits each)
//   almost_full       per-channel occupancy >= AF_THRESH

module fifo_rr_mux #(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 2,
    parameter int N_CH      = 4,
    parameter int LOG_N_CH  = 2,
    parameter int AF_THRESH = 3
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [N_CH-1:0]                 s_valid,
    output logic [N_CH-1:0]                 s_ready,
    input  logic [N_CH*WIDTH-1:0]           s_data,
    input  logic [N_CH-1:0]                 flush,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [WIDTH-1:0]                m_data,
    output logic [LOG_N_CH-1:0]             m_ch,
    output logic [N_CH*(LOG_DEPTH+1)-1:0]   occupancy,
    output logic [N_CH-1:0]                 almost_full
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int PTR_W = LOG_DEPTH + 1;
    localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]    AF_T     = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0]    DEPTH_P  = PTR_W'(DEPTH);
    localparam logic [LOG_N_CH-1:0] LAST_CH  = LOG_N_CH'(N_CH - 1);

    logic [PTR_W-1:0]    wr_ptr_q [N_CH];
    logic [PTR_W-1:0]    wr_ptr_d [N_CH];
    logic [PTR_W-1:0]    rd_ptr_q [N_CH];
    logic [PTR_W-1:0]    rd_ptr_d [N_CH];
    logic [PTR_W-1:0]    occ      [N_CH];
    logic [WIDTH-1:0]    mem_q    [N_CH][DEPTH];

    logic                lock_q, lock_d;
    logic [LOG_N_CH-1:0] lock_ch_q, lock_ch_d;
    logic [LOG_N_CH-1:0] last_sel_q, last_sel_d;

    logic [N_CH-1:0]     empty, full, wr_en;
    logic [LOG_N_CH-1:0] rr_ch, grant;
    logic                any_cand, pop;

    // Per-channel status; the pointer MSB separates full from empty.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][LOG_DEPTH-1:0] == rd_ptr_q[i][LOG_DEPTH-1:0]) &&
                       (wr_ptr_q[i][LOG_DEPTH] != rd_ptr_q[i][LOG_DEPTH]);
            s_ready[i]     = rstn & ~full[i] & ~flush[i];
            wr_en[i]       = s_valid[i] & s_ready[i];
            occ[i]         = wr_ptr_q[i] - rd_ptr_q[i];
            almost_full[i] = (occ[i] >= AF_T);
            occupancy[i*PTR_W +: PTR_W] = occ[i];
        end
    end

    // Round-robin search starts just after the last popped channel.
    always_comb begin : p_arb
        int   c;
        logic found;
        c        = 0;
        found    = 1'b0;
        rr_ch    = '0;
        any_cand = ~(&empty);
        for (int k = 1; k <= N_CH; k++) begin
            c = (int'(last_sel_q) + k) % N_CH;
            if (!found && !empty[LOG_N_CH'(c)]) begin
                found = 1'b1;
                rr_ch = LOG_N_CH'(c);
            end
        end
        // A stalled grant stays put so the consumer sees a stable beat.
        grant   = lock_q ? lock_ch_q : rr_ch;
        // Never offer a beat from a channel that is being cleared this cycle.
        m_valid = rstn & (any_cand | lock_q) & ~flush[grant];
        m_ch    = m_valid ? grant : '0;
        m_data  = mem_q[grant][rd_ptr_q[grant][LOG_DEPTH-1:0]];
        pop     = m_valid & m_ready;
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (flush[i]) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
            end else begin
                if (wr_en[i]) begin
                    wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;
                end
                if (pop && (grant == LOG_N_CH'(i))) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
                end
            end
        end
        lock_d     = lock_q;
        lock_ch_d  = lock_ch_q;
        last_sel_d = last_sel_q;
        if (pop) begin
            lock_d     = 1'b0;
            last_sel_d = grant;
        end else if (m_valid) begin
            lock_d    = 1'b1;
            lock_ch_d = grant;
        end else if (lock_q && flush[lock_ch_q]) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < N_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            lock_q     <= 1'b0;
            lock_ch_q  <= '0;
            last_sel_q <= LAST_CH;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            lock_q     <= lock_d;
            lock_ch_q  <= lock_ch_d;
            last_sel_q <= last_sel_d;
        end
    end

    // Payload storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (wr_en[i]) begin
                mem_q[i][wr_ptr_q[i][LOG_DEPTH-1:0]] <= s_data[i*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chk
        a_no_write_full: assert property (@(posedge clk) disable iff (!rstn)
            !(wr_en[g] && full[g]));
        a_occ_range: assert property (@(posedge clk) disable iff (!rstn)
            occ[g] <= DEPTH_P);
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (!rstn)
        (m_valid && !m_ready && !(|flush)) |=>
        ((|flush) || ($stable(m_ch) && $stable(m_data))));

endmodule
